// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the register file with reservation scoreboard.
package regfile_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned NREGS_DEF  = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned ZERO_REG   = 0;

  // True for architectural registers that hold state: nonzero and below nregs.
  function automatic logic reg_valid(input int unsigned addr, input int unsigned nregs);
    return (addr != ZERO_REG) && (addr < nregs);
  endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Read, writeback and reservation signals of regfile_scoreboard.
interface regfile_scoreboard_if
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
);
  logic [ADDR_W-1:0] iAddrA;
  logic [ADDR_W-1:0] iAddrB;
  logic [DATA_W-1:0] oRegA;
  logic [DATA_W-1:0] oRegB;
  logic              oBusyA;
  logic              oBusyB;
  logic              iWrite;
  logic [ADDR_W-1:0] iAddrC;
  logic [DATA_W-1:0] iRegC;
  logic              iRsv;
  logic [ADDR_W-1:0] iRsvAddr;
  logic              oRsvRdy;
  logic              iFlush;
  logic [ADDR_W:0]   oBusyCnt;

  modport master (
    output iAddrA, iAddrB, iWrite, iAddrC, iRegC, iRsv, iRsvAddr, iFlush,
    input  oRegA, oRegB, oBusyA, oBusyB, oRsvRdy, oBusyCnt
  );

  modport slave (
    input  iAddrA, iAddrB, iWrite, iAddrC, iRegC, iRsv, iRsvAddr, iFlush,
    output oRegA, oRegB, oBusyA, oBusyB, oRsvRdy, oBusyCnt
  );
endinterface

// File: rtl/rf_busy_table.sv
// Busy-bit scoreboard: reserve, writeback clear, flush and registered popcount.
module rf_busy_table
  import regfile_pkg::*;
#(
  parameter int unsigned NREGS  = NREGS_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              rsv,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic              flush,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  output logic              busy_a,
  output logic              busy_b,
  output logic              rsv_rdy,
  output logic [ADDR_W:0]   busy_cnt
);
  localparam int unsigned IDX_W = $clog2(NREGS);

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic [ADDR_W:0]  cnt_nxt;
  logic             rsv_ok;

  assign busy_a  = reg_valid(32'(addr_a), NREGS) ? busy[addr_a[IDX_W-1:0]] : 1'b0;
  assign busy_b  = reg_valid(32'(addr_b), NREGS) ? busy[addr_b[IDX_W-1:0]] : 1'b0;
  assign rsv_ok  = reg_valid(32'(rsv_addr), NREGS) ? busy[rsv_addr[IDX_W-1:0]] : 1'b0;
  assign rsv_rdy = !rsv_ok || (wr_en && (wr_addr == rsv_addr));

  // Order matters: write clears, then an accepted reserve re-sets, then flush wins.
  always_comb begin
    busy_nxt = busy;
    if (wr_valid)
      busy_nxt[wr_addr[IDX_W-1:0]] = 1'b0;
    if (rsv && rsv_rdy && reg_valid(32'(rsv_addr), NREGS))
      busy_nxt[rsv_addr[IDX_W-1:0]] = 1'b1;
    if (flush)
      busy_nxt = '0;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int unsigned i = 0; i < NREGS; i++)
      cnt_nxt = cnt_nxt + (ADDR_W+1)'(busy_nxt[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end
endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with destination-reservation scoreboard.
// Optional write-to-read bypass selected by macro REGFILE_BYPASS_EN.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned NREGS  = NREGS_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input logic                 iClk,
  input logic                 iRst,
  regfile_scoreboard_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(NREGS);

  logic [DATA_W-1:0] regs [NREGS];
  logic              wr_valid;
  logic [DATA_W-1:0] raw_a;
  logic [DATA_W-1:0] raw_b;
  logic              busy_a;
  logic              busy_b;

  assign wr_valid = bus.iWrite && reg_valid(32'(bus.iAddrC), NREGS);

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      for (int unsigned i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else if (wr_valid) begin
      regs[bus.iAddrC[IDX_W-1:0]] <= bus.iRegC;
    end
  end

  assign raw_a = reg_valid(32'(bus.iAddrA), NREGS) ? regs[bus.iAddrA[IDX_W-1:0]] : '0;
  assign raw_b = reg_valid(32'(bus.iAddrB), NREGS) ? regs[bus.iAddrB[IDX_W-1:0]] : '0;

  rf_busy_table #(
    .NREGS (NREGS),
    .ADDR_W(ADDR_W)
  ) u_busy (
    .clk     (iClk),
    .rst     (iRst),
    .wr_en   (bus.iWrite),
    .wr_valid(wr_valid),
    .wr_addr (bus.iAddrC),
    .rsv     (bus.iRsv),
    .rsv_addr(bus.iRsvAddr),
    .flush   (bus.iFlush),
    .addr_a  (bus.iAddrA),
    .addr_b  (bus.iAddrB),
    .busy_a  (busy_a),
    .busy_b  (busy_b),
    .rsv_rdy (bus.oRsvRdy),
    .busy_cnt(bus.oBusyCnt)
  );

`ifdef REGFILE_BYPASS_EN
  logic hit_a;
  logic hit_b;

  assign hit_a      = wr_valid && (bus.iAddrA == bus.iAddrC);
  assign hit_b      = wr_valid && (bus.iAddrB == bus.iAddrC);
  assign bus.oRegA  = hit_a ? bus.iRegC : raw_a;
  assign bus.oRegB  = hit_b ? bus.iRegC : raw_b;
  assign bus.oBusyA = hit_a ? 1'b0 : busy_a;
  assign bus.oBusyB = hit_b ? 1'b0 : busy_b;
`else
  assign bus.oRegA  = raw_a;
  assign bus.oRegB  = raw_b;
  assign bus.oBusyA = busy_a;
  assign bus.oBusyB = busy_b;
`endif
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard (NREGS=32, ADDR_W=6).
module tb_regfile_scoreboard;
  logic iClk = 1'b0;
  logic iRst = 1'b1;
  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  regfile_scoreboard_if #(.DATA_W(32), .ADDR_W(6)) bus ();

  regfile_scoreboard #(
    .DATA_W(32),
    .NREGS (32),
    .ADDR_W(6)
  ) dut (
    .iClk(iClk),
    .iRst(iRst),
    .bus (bus.slave)
  );

  always #5 iClk = ~iClk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are changed and outputs sampled 1-2 ns later.
  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic idle();
    bus.iWrite = 1'b0; bus.iRsv = 1'b0; bus.iFlush = 1'b0;
  endtask

  initial begin
    bus.iAddrA = '0; bus.iAddrB = '0; bus.iAddrC = '0; bus.iRegC = '0;
    bus.iRsvAddr = '0; idle();
    // Activity during reset must be ignored
    bus.iWrite = 1'b1; bus.iAddrC = 6'd5; bus.iRegC = 32'h1111_1111;
    bus.iRsv = 1'b1; bus.iRsvAddr = 6'd5;
    tick(); tick();
    idle(); bus.iAddrA = 6'd5;
    #1;
    check("rst_regA", bus.oRegA, 0);
    check("rst_busyA", bus.oBusyA, 0);
    check("rst_cnt", bus.oBusyCnt, 0);
    check("rst_rdy", bus.oRsvRdy, 1);
    iRst = 1'b0;

    // Write r5, read back through A; B reads r0
    tick();
    bus.iWrite = 1'b1; bus.iAddrC = 6'd5; bus.iRegC = 32'hDEAD_BEEF;
    bus.iAddrA = 6'd5; bus.iAddrB = 6'd0;
    #1;
    check("wr5_same_cycle", bus.oRegA, BYP ? 64'hDEAD_BEEF : 64'h0);
    tick(); idle(); #1;
    check("wr5_regA", bus.oRegA, 64'hDEAD_BEEF);
    check("r0_regB", bus.oRegB, 0);

    // Writes to r0 and r40 (out of range) are dropped
    bus.iWrite = 1'b1; bus.iAddrC = 6'd0; bus.iRegC = 32'h1234;
    tick();
    bus.iAddrC = 6'd40; bus.iRegC = 32'h9999; bus.iAddrA = 6'd0; bus.iAddrB = 6'd40;
    #1;
    check("r40_same_cycle", bus.oRegB, 0);
    tick(); idle(); #1;
    check("r0_read", bus.oRegA, 0);
    check("r40_read", bus.oRegB, 0);
    check("r0_r40_cnt", bus.oBusyCnt, 0);

    // Highest valid register
    bus.iWrite = 1'b1; bus.iAddrC = 6'd31; bus.iRegC = 32'hCAFE_0031; bus.iAddrB = 6'd31;
    tick(); idle(); #1;
    check("r31_read", bus.oRegB, 64'hCAFE_0031);

    // Reserve r3 twice, then writeback clears it
    bus.iRsv = 1'b1; bus.iRsvAddr = 6'd3; bus.iAddrA = 6'd3;
    #1;
    check("rsv3_rdy1", bus.oRsvRdy, 1);
    check("rsv3_busy_before", bus.oBusyA, 0);
    tick(); #1;
    check("rsv3_rdy2", bus.oRsvRdy, 0);
    check("rsv3_busyA", bus.oBusyA, 1);
    check("rsv3_cnt", bus.oBusyCnt, 1);
    tick(); #1;
    check("rsv3_cnt_hold", bus.oBusyCnt, 1);
    bus.iRsv = 1'b0; bus.iWrite = 1'b1; bus.iAddrC = 6'd3; bus.iRegC = 32'h55;
    #1;
    check("wr3_rdy_override", bus.oRsvRdy, 1);
    check("wr3_busy_same_cycle", bus.oBusyA, BYP ? 64'd0 : 64'd1);
    tick(); idle(); #1;
    check("wr3_busy_clr", bus.oBusyA, 0);
    check("wr3_cnt", bus.oBusyCnt, 0);
    check("wr3_data", bus.oRegA, 64'h55);

    // Same-cycle write and reserve of r7: data lands, busy stays set
    bus.iWrite = 1'b1; bus.iAddrC = 6'd7; bus.iRegC = 32'hA5;
    bus.iRsv = 1'b1; bus.iRsvAddr = 6'd7; bus.iAddrA = 6'd7;
    #1;
    check("wr7_rsv_rdy", bus.oRsvRdy, 1);
    tick(); idle(); #1;
    check("wr7_data", bus.oRegA, 64'hA5);
    check("wr7_busy", bus.oBusyA, 1);
    check("wr7_cnt", bus.oBusyCnt, 1);

    // Reserve r1,r2,r4 then flush alongside reserve r6 and write r10
    bus.iRsv = 1'b1; bus.iRsvAddr = 6'd1; tick();
    bus.iRsvAddr = 6'd2; tick();
    bus.iRsvAddr = 6'd4; tick(); #1;
    check("pre_flush_cnt", bus.oBusyCnt, 4);
    bus.iRsvAddr = 6'd6; bus.iFlush = 1'b1;
    bus.iWrite = 1'b1; bus.iAddrC = 6'd10; bus.iRegC = 32'h1010;
    bus.iAddrA = 6'd7; bus.iAddrB = 6'd6;
    tick(); idle(); #1;
    check("flush_cnt", bus.oBusyCnt, 0);
    check("flush_busy7", bus.oBusyA, 0);
    check("flush_busy6", bus.oBusyB, 0);
    bus.iAddrA = 6'd10; bus.iAddrB = 6'd7; #1;
    check("flush_wr10", bus.oRegA, 64'h1010);
    check("flush_keeps_r7", bus.oRegB, 64'hA5);

    // Asynchronous reset mid-cycle
    bus.iRsv = 1'b1; bus.iRsvAddr = 6'd2; bus.iAddrA = 6'd2; bus.iAddrB = 6'd5;
    tick(); #1;
    check("rsv2_cnt", bus.oBusyCnt, 1);
    check("rsv2_rdy", bus.oRsvRdy, 0);
    iRst = 1'b1; #1;
    check("arst_cnt", bus.oBusyCnt, 0);
    check("arst_busyA", bus.oBusyA, 0);
    check("arst_regB", bus.oRegB, 0);
    check("arst_rdy", bus.oRsvRdy, 1);
    tick(); tick(); #1;
    check("arst_rsv_ignored", bus.oBusyCnt, 0);
    idle(); iRst = 1'b0;

    // Bypass behaviour: r9 old=0x11, then write 0x77 while reading r9
    tick();
    bus.iWrite = 1'b1; bus.iAddrC = 6'd9; bus.iRegC = 32'h11; bus.iAddrA = 6'd9;
    tick();
    bus.iRegC = 32'h77; #1;
    check("byp_r9_same", bus.oRegA, BYP ? 64'h77 : 64'h11);
    tick(); idle(); #1;
    check("byp_r9_next", bus.oRegA, 64'h77);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
